// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack memory port and
// hands instruction/pc/pcNext to execute over valid/ready, with redirect and fault flags.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned PC_STEP        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pcNext,
    output logic        fetch_misaligned,
    output logic        fetch_timeout,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [31:0] STEP    = 32'(PC_STEP);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Handshakes: memory transfers when imem_req && imem_ack at a rising edge, and the
    // request (with its address) is never withdrawn before that; execute consumes when
    // out_valid && out_ready at a rising edge, and outputs are frozen until then.
    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_fetch_pc;
    logic        r_discard;
    logic        r_out_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_next;
    logic        r_misaligned;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout;

    logic w_redir_ok;
    logic w_redir_bad;

    assign w_redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign w_redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_fetch_pc   <= RESET_PC;
            r_discard    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_instr      <= 32'h0;
            r_pc         <= RESET_PC;
            r_pc_next    <= RESET_PC + STEP;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                S_REQ, S_WAIT: begin
                    if (!r_req) begin
                        // Only reached straight out of reset: nothing is outstanding yet.
                        if (w_redir_bad) begin
                            r_misaligned <= 1'b1;
                            r_state      <= S_ERROR;
                        end else begin
                            r_req  <= 1'b1;
                            r_addr <= w_redir_ok ? redirect_target : r_fetch_pc;
                            if (w_redir_ok) r_fetch_pc <= redirect_target;
                        end
                    end else if (w_redir_bad) begin
                        r_misaligned <= 1'b1;
                        r_discard    <= 1'b0;
                        r_state      <= S_ERROR;
                        if (imem_ack) r_req <= 1'b0;
                    end else if (imem_ack) begin
                        if (w_redir_ok) begin
                            r_fetch_pc <= redirect_target;
                            r_addr     <= redirect_target;
                            r_discard  <= 1'b0;
                            r_state    <= S_REQ;
                        end else if (r_discard) begin
                            // Stale response dropped; reissue straight away at the latched target.
                            r_addr    <= r_fetch_pc;
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_instr     <= imem_rdata;
                            r_pc        <= r_fetch_pc;
                            r_pc_next   <= r_fetch_pc + STEP;
                            r_out_valid <= 1'b1;
                            r_req       <= 1'b0;
                            r_state     <= S_HOLD;
                        end
                    end else begin
                        if (w_redir_ok) begin
                            r_fetch_pc <= redirect_target;
                            r_discard  <= 1'b1;
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (w_redir_bad) begin
                        r_out_valid  <= 1'b0;
                        r_misaligned <= 1'b1;
                        r_state      <= S_ERROR;
                    end else if (w_redir_ok) begin
                        r_out_valid <= 1'b0;
                        r_fetch_pc  <= redirect_target;
                        r_addr      <= redirect_target;
                        r_req       <= 1'b1;
                        r_state     <= S_REQ;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fetch_pc  <= r_pc_next;
                        r_addr      <= r_pc_next;
                        r_req       <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                default: begin
                    // ERROR: only let an in-flight request finish, then stay parked.
                    if (r_req && imem_ack) r_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else if (r_req && !imem_ack) begin
            if (r_wait_cnt == TO_LAST) begin
                r_wait_cnt <= 8'd0;
                r_timeout  <= 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
                r_timeout  <= 1'b0;
            end
        end else begin
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end
    end

    assign imem_req         = r_req;
    assign imem_addr        = r_addr;
    assign out_valid        = r_out_valid;
    assign instruction      = r_instr;
    assign pc               = r_pc;
    assign pcNext           = r_pc_next;
    assign fetch_misaligned = r_misaligned;
    assign fetch_timeout    = r_timeout;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized
// run checked against a program-order model of the delivered instruction stream.
module tb_instruction_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        fetch_misaligned;
  logic        fetch_timeout;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  int mem_lat = 0;
  bit mem_rand = 1'b0;
  int cur_lat = 0;
  int wcnt = 0;
  bit acked = 1'b0;

  logic [31:0] exp_q[$];

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP(4),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .instruction(instruction),
    .pc(pc),
    .pcNext(pcNext),
    .fetch_misaligned(fetch_misaligned),
    .fetch_timeout(fetch_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_mem(input int lat, input bit rnd);
    mem_lat = lat;
    mem_rand = rnd;
    cur_lat = rnd ? int'($urandom_range(0, 3)) : lat;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (acked || !rst_n) wcnt = 0;
      acked = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      if (rst_n && imem_req) begin
        if (wcnt >= cur_lat) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          acked = 1'b1;
          cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 00000000", instruction); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    checks++; if (pcNext !== 32'h4) begin failures++; $display("FAIL reset_pcnext: got %h expected 00000004", pcNext); end
    checks++; if (fetch_misaligned !== 1'b0 || fetch_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got mis=%b to=%b expected 0 0", fetch_misaligned, fetch_timeout);
    end
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL first_req: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    int last_cyc;
    logic [31:0] e;
    logic [31:0] exp_pc;
    set_mem(0, 1'b0);
    do_reset();
    out_ready = 1'b1;
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    last_cyc = -1;
    exp_pc = 32'h0;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      step();
      if (imem_req && imem_ack) begin
        e = exp_q.pop_front();
        checks++; if (imem_addr !== e) begin failures++; $display("FAIL zw_addr: got %h expected %h", imem_addr, e); end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != 2) begin failures++; $display("FAIL zw_spacing: got %0d expected 2", cyc - last_cyc); end
        end
        last_cyc = cyc;
      end
      if (out_valid) begin
        checks++;
        if (pc !== exp_pc || pcNext !== exp_pc + 32'd4 || instruction !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL zw_out: got pc=%h next=%h ins=%h expected %h %h %h", pc, pcNext, instruction, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL zw_budget: got %0d fetches left expected 0", exp_q.size()); end
    out_ready = 1'b0;
  endtask

  task automatic test_latency_hold();
    int stable;
    logic [31:0] s_ins, s_pc, s_nx;
    set_mem(3, 1'b0);
    do_reset();
    step();
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (!imem_req || imem_addr !== 32'h0) break;
      stable++;
      if (imem_ack) break;
      step();
    end
    checks++; if (stable != 4) begin failures++; $display("FAIL lat_stable: got %0d expected 4", stable); end
    step();
    checks++; if (out_valid !== 1'b1 || pc !== 32'h0 || instruction !== mem_word(32'h0)) begin
      failures++; $display("FAIL lat_capture: got v=%b pc=%h ins=%h expected 1 00000000 %h", out_valid, pc, instruction, mem_word(32'h0));
    end
    s_ins = mem_word(32'h0);
    s_pc = 32'h0;
    s_nx = 32'h4;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || instruction !== s_ins || pc !== s_pc || pcNext !== s_nx || imem_req !== 1'b0) begin
        failures++; $display("FAIL lat_frozen: got v=%b pc=%h next=%h req=%b expected 1 %h %h 0", out_valid, pc, pcNext, imem_req, s_pc, s_nx);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL lat_next: got v=%b req=%b addr=%h expected 0 1 00000004", out_valid, imem_req, imem_addr);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit found;
    bit delivered;
    logic [31:0] e;
    set_mem(3, 1'b0);
    do_reset();
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (imem_req && imem_addr == 32'h8) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rw_reach: got no fetch at 00000008 expected one"); end
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    exp_q = {32'h8, 32'h100};
    step();
    redirect_valid = 1'b0;
    delivered = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_ack && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (imem_addr !== e) begin failures++; $display("FAIL rw_addr: got %h expected %h", imem_addr, e); end
      end
      if (out_valid) begin
        checks++;
        if (pc !== 32'h100 || pcNext !== 32'h104 || instruction !== mem_word(32'h100)) begin
          failures++; $display("FAIL rw_out: got pc=%h next=%h ins=%h expected 00000100 00000104 %h", pc, pcNext, instruction, mem_word(32'h100));
        end
        delivered = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!delivered || exp_q.size() != 0) begin
      failures++; $display("FAIL rw_done: got delivered=%b left=%0d expected 1 0", delivered, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_hold();
    bit found;
    bit delivered;
    set_mem(0, 1'b0);
    do_reset();
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid && pc == 32'h10) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rh_reach: got no pc 00000010 expected one"); end
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failures++; $display("FAIL rh_next: got v=%b req=%b addr=%h expected 0 1 00000040", out_valid, imem_req, imem_addr);
    end
    delivered = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) begin delivered = 1'b1; break; end
    end
    checks++; if (!delivered || pc !== 32'h40 || pcNext !== 32'h44) begin
      failures++; $display("FAIL rh_out: got v=%b pc=%h next=%h expected 1 00000040 00000044", delivered, pc, pcNext);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    set_mem(3, 1'b0);
    do_reset();
    out_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    step();
    redirect_valid = 1'b0;
    checks++; if (fetch_misaligned !== 1'b1 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL mis_enter: got mis=%b v=%b req=%b addr=%h expected 1 0 1 00000000", fetch_misaligned, out_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 10; i++) begin
      if (imem_ack) break;
      step();
    end
    step();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (imem_req !== 1'b0 || fetch_misaligned !== 1'b1 || out_valid !== 1'b0) begin
        failures++; $display("FAIL mis_park: got req=%b mis=%b v=%b expected 0 1 0", imem_req, fetch_misaligned, out_valid);
      end
      redirect_valid = (i == 5);
      redirect_target = 32'h200;
      step();
    end
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (fetch_misaligned !== 1'b0 || imem_req !== 1'b0 || out_valid !== 1'b0 || pc !== 32'h0) begin
      failures++; $display("FAIL mis_reset: got mis=%b req=%b v=%b pc=%h expected 0 0 0 00000000", fetch_misaligned, imem_req, out_valid, pc);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL mis_restart: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit got_ack;
    set_mem(40, 1'b0);
    do_reset();
    out_ready = 1'b1;
    exp_q.delete();
    for (int j = 1; j * TIMEOUT + 1 <= 41; j++) exp_q.push_back(32'(j * TIMEOUT + 1));
    got_ack = 1'b0;
    step();
    for (int k = 1; k <= 50; k++) begin
      if (fetch_timeout) begin
        checks++;
        if (exp_q.size() == 0 || 32'(k) !== exp_q[0]) begin
          failures++; $display("FAIL to_pulse: got pulse at cycle %0d expected %0d", k, (exp_q.size() > 0) ? int'(exp_q[0]) : -1);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (imem_ack) begin
        checks++; if (k != 41) begin failures++; $display("FAIL to_ack: got cycle %0d expected 41", k); end
        got_ack = 1'b1;
        break;
      end
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL to_req: got %b expected 1", imem_req); end
      step();
    end
    step();
    checks++; if (!got_ack || exp_q.size() != 0 || out_valid !== 1'b1 || pc !== 32'h0) begin
      failures++; $display("FAIL to_end: got ack=%b left=%0d v=%b pc=%h expected 1 0 1 00000000", got_ack, exp_q.size(), out_valid, pc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    set_mem(0, 1'b0);
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_req: got req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
    end
    step();
    checks++; if (out_valid !== 1'b1 || pc !== 32'hFFFF_FFFC || pcNext !== 32'h0 || instruction !== mem_word(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_out: got v=%b pc=%h next=%h expected 1 fffffffc 00000000", out_valid, pc, pcNext);
    end
    out_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap_next: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    bit prev_pending;
    bit rv;
    int consumed;
    set_mem(0, 1'b1);
    do_reset();
    exp_pc = 32'h0;
    prev_pending = 1'b0;
    prev_addr = 32'h0;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (prev_pending) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          failures++; $display("FAIL rnd_hold: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, prev_addr);
        end
      end
      if (out_valid) begin
        checks++;
        if (pc !== exp_pc || pcNext !== exp_pc + 32'd4 || instruction !== mem_word(exp_pc)) begin
          failures++; $display("FAIL rnd_out: got pc=%h next=%h ins=%h expected %h %h %h", pc, pcNext, instruction, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
        end
      end
      rv = ($urandom_range(0, 15) == 0);
      redirect_valid = rv;
      redirect_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
      out_ready = ($urandom_range(0, 2) != 0);
      if (rv) exp_pc = redirect_target;
      else if (out_valid && out_ready) begin
        consumed++;
        exp_pc = exp_pc + 32'd4;
      end
      prev_pending = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (consumed < 100 || fetch_misaligned !== 1'b0) begin
      failures++; $display("FAIL rnd_progress: got consumed=%0d mis=%b expected >=100 0", consumed, fetch_misaligned);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_zero_wait();
    test_latency_hold();
    test_redirect_wait();
    test_redirect_hold();
    test_misaligned();
    test_timeout();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule
